shift_unit_pipe: RTL and testbench

- Two-stage pipelined 32-bit shifter for the RV32 execute path: SLL, SRL, SRA.
- Sits directly downstream of the 5-to-32 shift-amount decoder and consumes its one-hot shift vector together with the operand and op code.
- Converts the one-hot amount back to a binary amount and performs a logarithmic barrel shift.
- Valid/ready handshakes on both sides; one result per cycle sustained.

---
 rtl/shift_unit_pipe.sv | 124 ++++++++++++
 tb/tb_shift_unit_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined RV32 shifter (SLL/SRL/SRA) fed by a one-hot shift amount.
// S1 decodes the one-hot amount and flags malformed requests; S2 holds the barrel-shift result.
module shift_unit_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [XLEN-1:0]      a,
  input  logic [31:0]          shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  logic            s1_valid;
  logic [1:0]      s1_op;
  logic [XLEN-1:0] s1_a;
  logic [4:0]      s1_shamt;
  logic            s1_bad;
  logic            s2_valid;

  logic            s2_free;
  logic            s1_adv;
  logic            accept;

  logic [4:0]      enc_shamt;
  logic            enc_onehot;
  logic [XLEN-1:0] shifted;
  logic            sra_fill;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Bit b of the amount is the OR of every one-hot position whose index has bit b set.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    enc_shamt = '0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 32; k++) begin
        if (k[b]) enc_shamt[b] = enc_shamt[b] | shift[k];
      end
    end
  end

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
  assign enc_onehot = (|shift) && !(|(shift & (shift - 32'd1)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: S1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op    <= op;
      s1_a     <= a;
      s1_shamt <= enc_shamt;
      s1_bad   <= !enc_onehot || (op == OP_RSV);
    end
  end

  // Logarithmic shifter: levels of 1, 2, 4, 8 and 16 positions.
  always_comb begin
    shifted  = s1_a;
    sra_fill = s1_a[XLEN-1] && (s1_op == OP_SRA);
    for (int i = 0; i < 5; i++) begin
      if (s1_shamt[i]) begin
        if (s1_op == OP_SLL) begin
          shifted = shifted << (1 << i);
        end else begin
          shifted = (shifted >> (1 << i)) |
                    ({XLEN{sra_fill}} & ~({XLEN{1'b1}} >> (1 << i)));
        end
      end
    end
  end

  // result/err only load on S1 advance, so they hold while stalled or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      result   <= s1_bad ? '0 : shifted;
      err      <= s1_bad;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: inputs change 1ns after posedge, outputs sampled at negedge;
// a negedge monitor compares every output transfer against a queue of hand-computed results.
module tb_shift_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int stalls = 0;
  bit mon_en = 1'b0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  shift_unit_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A transfer seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", result, e[32:1]);
        check("err", {31'd0, err}, {31'd0, e[0]});
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [31:0] av, input logic [31:0] sh,
                      input logic [31:0] exp_res, input logic exp_err);
    bit done = 1'b0;
    in_valid = 1'b1; op = o; a = av; shift = sh;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_res, exp_err});
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    int idx;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; shift = 32'h1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single SLL by 31; result appears after the second edge counting the accept edge.
    send(2'b00, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    check("lat_one_edge", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_two_edges", {31'd0, out_valid}, 32'd1);
    drain();

    // SRA vs SRL by 4, and shamt 0 passthrough on every legal op.
    send(2'b11, 32'hF000_0000, 32'h0000_0010, 32'hFF00_0000, 1'b0);
    send(2'b01, 32'hF000_0000, 32'h0000_0010, 32'h0F00_0000, 1'b0);
    send(2'b11, 32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 1'b0);
    send(2'b01, 32'h8765_4321, 32'h0000_0001, 32'h8765_4321, 1'b0);
    send(2'b00, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
    send(2'b11, 32'h7000_0000, 32'h0000_0100, 32'h0070_0000, 1'b0);
    send(2'b00, 32'h0000_00A5, 32'h0001_0000, 32'h00A5_0000, 1'b0);
    drain();
    check("err_cnt_clean", {24'd0, err_cnt}, 32'd0);

    // Malformed: no bit, two bits, reserved op.
    send(2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0, 1'b1);
    send(2'b01, 32'h1234_5678, 32'h0000_0003, 32'h0, 1'b1);
    send(2'b10, 32'h1234_5678, 32'h0000_0004, 32'h0, 1'b1);
    drain();
    check("err_cnt_3", {24'd0, err_cnt}, 32'd3);

    // Backpressure: only two transactions fit, output holds while stalled.
    out_ready = 1'b0;
    idx = 0;
    x0 = xfers;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; op = 2'b00; a = 32'h1; shift = 32'h1 << idx;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({32'h1 << idx, 1'b0});
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepts", idx, 32'd2);
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held = result;
    check("bp_head", held, 32'h1);
    repeat (3) @(negedge clk);
    check("bp_stable", result, held);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 32'h1, 32'h4, 32'h4, 1'b0);
    send(2'b00, 32'h1, 32'h8, 32'h8, 1'b0);
    drain();
    check("bp_xfers", xfers - x0, 32'd4);

    // Full rate: 32 back-to-back SRL of all-ones, no input stall allowed.
    stalls = 0;
    x0 = xfers;
    for (int k = 0; k < 32; k++) begin
      send(2'b01, 32'hFFFF_FFFF, 32'h1 << k, 32'hFFFF_FFFF >> k, 1'b0);
    end
    check("fr_stalls", stalls, 32'd0);
    @(negedge clk);
    check("fr_tail_valid", {31'd0, out_valid}, 32'd1);
    drain();
    check("fr_xfers", xfers - x0, 32'd32);

    // Saturation: 252 more errors reach 255, two more must not wrap.
    for (int k = 0; k < 252; k++) send(2'b10, 32'h0, 32'h1, 32'h0, 1'b1);
    drain();
    check("err_cnt_255", {24'd0, err_cnt}, 32'd255);
    send(2'b00, 32'h5, 32'h0, 32'h0, 1'b1);
    send(2'b00, 32'h5, 32'h6, 32'h0, 1'b1);
    drain();
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset with S1 and S2 both full; nothing stale may emerge afterwards.
    out_ready = 1'b0;
    send(2'b00, 32'h3, 32'h2, 32'h6, 1'b0);
    send(2'b00, 32'h3, 32'h4, 32'hC, 1'b0);
    @(negedge clk);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    x0 = xfers;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale", xfers - x0, 32'd0);
    send(2'b11, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
